// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch sequencer and the control unit: the opcode
// encodings and the fetch FSM state type.
package cpu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_REG0 = 3'b010;
  localparam logic [2:0] OP_REG1 = 3'b011;
  localparam logic [2:0] OP_REG2 = 3'b100;
  localparam logic [2:0] OP_REG3 = 3'b101;
  localparam logic [2:0] OP_MEMW = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [2:0] op);
    return op == OP_HALT;
  endfunction

  function automatic logic is_jmp(input logic [2:0] op);
    return op == OP_JMP;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: a synchronous load takes priority over the increment, and the
// increment wraps from all-ones back to zero.
module fetch_pc_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: fetches over req/ack, holds the word in IR,
// issues a one-cycle En pulse per instruction and paces the next fetch.
module instr_fetch_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stall,
  input  logic                   Imem_ack,
  input  logic [INSTR_WIDTH-1:0] Imem_data,
  output logic                   Imem_req,
  output logic [ADDR_WIDTH-1:0]  Imem_addr,
  output logic [2:0]             Opcode,
  output logic [INSTR_WIDTH-4:0] Operand,
  output logic                   En,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   Busy,
  output logic                   Halted
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  fetch_state_t           state;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   en_q;
  logic                   req_q;
  logic [CNT_W-1:0]       exec_cnt;

  logic                   fetch_done;
  logic [INSTR_WIDTH-1:0] issue_word;
  logic [2:0]             issue_op;
  logic [INSTR_WIDTH-4:0] issue_operand;
  logic                   issue_go;
  logic                   pc_load;
  logic [ADDR_WIDTH-1:0]  pc;

  // The word being decided on is the arriving one on the ack edge, else the held IR.
  assign fetch_done    = (state == FETCH) && Imem_ack;
  assign issue_word    = (state == FETCH) ? Imem_data : ir;
  assign issue_op      = issue_word[INSTR_WIDTH-1 -: 3];
  assign issue_operand = issue_word[INSTR_WIDTH-4:0];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    issue_go = 1'b0;
    if (fetch_done) begin
      issue_go = !Stall && !is_halt(issue_op);
    end else if (state == ISSUE && !en_q) begin
      issue_go = !Stall && !is_halt(issue_op);
    end
  end

  // A JMP loads its target on the same edge that raises En, overriding the increment.
  assign pc_load = issue_go && is_jmp(issue_op);

  fetch_pc_reg #(
    .WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clk      (Clk),
    .rst      (Reset),
    .inc      (fetch_done),
    .load     (pc_load),
    .load_val (ADDR_WIDTH'(issue_operand)),
    .pc       (pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ir       <= '0;
      en_q     <= 1'b0;
      req_q    <= 1'b0;
      exec_cnt <= '0;
    end else begin
      en_q <= issue_go;
      unique case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state <= FETCH;
            req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (Imem_ack) begin
            ir    <= Imem_data;
            req_q <= 1'b0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // en_q high means the issue pulse is on this cycle; otherwise wait out Stall.
          if (en_q) begin
            state    <= EXEC;
            exec_cnt <= EXEC_LOAD;
          end else if (!Stall && is_halt(ir[INSTR_WIDTH-1 -: 3])) begin
            state <= HALTED;
          end
        end
        EXEC: begin
          if (exec_cnt == '0) begin
            state <= FETCH;
            req_q <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_req  = req_q;
  assign Imem_addr = pc;
  assign PC        = pc;
  assign Opcode    = ir[INSTR_WIDTH-1 -: 3];
  assign Operand   = ir[INSTR_WIDTH-4:0];
  assign En        = en_q;
  assign Busy      = (state == FETCH) || (state == ISSUE) || (state == EXEC);
  assign Halted    = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboarded bench for instr_fetch_seq: a program-level reference model queues
// the expected issue stream and a monitor compares every En pulse against it.
`timescale 1ns/1ps
module tb_instr_fetch_seq;

  localparam int AW  = 8;
  localparam int IW  = 8;
  localparam int OPW = IW - 3;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Start;
  logic           Stall;
  logic           Imem_ack;
  logic [IW-1:0]  Imem_data;
  logic           Imem_req;
  logic [AW-1:0]  Imem_addr;
  logic [2:0]     Opcode;
  logic [OPW-1:0] Operand;
  logic           En;
  logic [AW-1:0]  PC;
  logic           Busy;
  logic           Halted;

  instr_fetch_seq #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .EXEC_CYCLES(2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stall    (Stall),
    .Imem_ack (Imem_ack),
    .Imem_data(Imem_data),
    .Imem_req (Imem_req),
    .Imem_addr(Imem_addr),
    .Opcode   (Opcode),
    .Operand  (Operand),
    .En       (En),
    .PC       (PC),
    .Busy     (Busy),
    .Halted   (Halted)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]     op;
    logic [OPW-1:0] opnd;
    logic [AW-1:0]  pc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [IW-1:0] mem [256];
  int            mem_lat     = 0;
  bit            spur_en     = 1'b0;
  bit            stall_rand  = 1'b0;
  bit            force_stall = 1'b0;
  int            last_req_cycles = 0;
  int            rsp_wait = 0;
  logic [AW-1:0] rsp_addr = '0;

  logic [AW-1:0] m_pc;
  bit            m_halted;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", name, budget);
  endtask

  // Reference model: walks the program as the architecture defines it.
  task automatic model_run(input int max_steps);
    logic [IW-1:0] w;
    exp_t          e;
    m_halted = 1'b0;
    for (int i = 0; i < max_steps && !m_halted; i++) begin
      w    = mem[m_pc];
      m_pc = m_pc + 8'd1;
      if (w[7:5] == 3'b001) begin
        m_halted = 1'b1;
      end else begin
        if (w[7:5] == 3'b111) m_pc = {3'b000, w[4:0]};
        e.op   = w[7:5];
        e.opnd = w[4:0];
        e.pc   = m_pc;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [IW-1:0] rand_normal();
    logic [2:0] op;
    case ($urandom_range(0, 5))
      0:       op = 3'b000;
      1:       op = 3'b010;
      2:       op = 3'b011;
      3:       op = 3'b100;
      4:       op = 3'b101;
      default: op = 3'b110;
    endcase
    return {op, 5'($urandom)};
  endfunction

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) mem[a] = 8'h20;
  endtask

  // Memory responder: acks after mem_lat extra cycles; optional spurious acks while idle.
  initial begin
    Imem_ack  = 1'b0;
    Imem_data = '0;
    forever begin
      @(posedge Clk);
      #1;
      Imem_ack = 1'b0;
      if (Reset) begin
        rsp_wait = 0;
      end else if (Imem_req) begin
        if (rsp_wait == 0) rsp_addr = Imem_addr;
        else check("addr_stable", 32'(Imem_addr), 32'(rsp_addr));
        if (rsp_wait >= mem_lat) begin
          Imem_ack        = 1'b1;
          Imem_data       = mem[Imem_addr];
          last_req_cycles = rsp_wait + 1;
          rsp_wait        = 0;
        end else begin
          rsp_wait++;
        end
      end else begin
        rsp_wait = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          Imem_ack  = 1'b1;
          Imem_data = 8'($urandom);
        end
      end
    end
  end

  initial begin
    Stall = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      Stall = force_stall || (stall_rand && $urandom_range(0, 2) == 0);
    end
  end

  // Monitor: every En pulse must match the head of the expected queue.
  initial forever begin
    @(negedge Clk);
    if (En) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_en: got issue opcode %b operand 0x%0h pc 0x%0h, expected no issue",
                 Opcode, Operand, PC);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_opcode",  32'(Opcode),  32'(mon_e.op));
        check("issue_operand", 32'(Operand), 32'(mon_e.opnd));
        check("issue_pc",      32'(PC),      32'(mon_e.pc));
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", 32'({Imem_req, En, Busy, Halted, Opcode, Operand, PC}), 32'h0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    check("start_with_reset_idle", 32'({Busy, Halted}), 32'h0);
    m_pc = '0;
  endtask

  task automatic pulse_start();
    @(posedge Clk);
    #1 Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge Clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail(name, budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_halted(input string name, input int budget);
    int c = 0;
    while (!Halted && c < budget) begin
      @(negedge Clk);
      c++;
    end
    if (!Halted) timeout_fail(name, budget);
    else check(name, 32'(PC), 32'(m_pc));
  endtask

  task automatic wait_req(input string name, input int budget);
    int c = 0;
    while (!Imem_req && c < budget) begin
      @(negedge Clk);
      c++;
    end
    if (!Imem_req) timeout_fail(name, budget);
  endtask

  initial begin
    int l;
    bit seen_drop;
    Reset = 1'b1;
    Start = 1'b0;
    fill_halt();
    do_reset();

    // Straight-line program, single-cycle memory.
    mem[0] = 8'h40; mem[1] = 8'h60; mem[2] = 8'hC5; mem[3] = 8'h20;
    mem_lat = 0;
    model_run(50);
    pulse_start();
    wait_drain("t1_issues", 100);
    wait_halted("t1_halt_pc", 50);
    check("t1_pc_literal", 32'(PC), 32'h4);

    // Slow memory: request and address held across the wait; Start while busy ignored.
    do_reset();
    fill_halt();
    mem[0] = 8'h4A;
    mem_lat = 5;
    model_run(50);
    pulse_start();
    pulse_start();
    wait_drain("t2_issue", 100);
    wait_halted("t2_halt_pc", 100);
    check("t2_req_cycles", 32'(last_req_cycles), 32'd6);

    // JMP 3 at address 0: next fetch goes to 0x03.
    do_reset();
    fill_halt();
    mem[0] = 8'hE3;
    mem_lat = 1;
    model_run(50);
    pulse_start();
    wait_drain("t3_jmp_issue", 50);
    wait_req("t3_next_req", 20);
    check("t3_jmp_addr", 32'(Imem_addr), 32'h3);
    wait_halted("t3_halt_pc", 50);

    // HALT at address 4, then resume from 0x05.
    do_reset();
    fill_halt();
    for (int a = 0; a < 4; a++) mem[a] = rand_normal();
    mem[5] = 8'h9A;
    mem_lat = 0;
    model_run(50);
    pulse_start();
    wait_drain("t4_issues", 100);
    wait_halted("t4_halt_pc", 50);
    check("t4_pc_literal", 32'(PC), 32'h5);
    check("t4_halted_quiet", 32'({Imem_req, Busy, Halted}), 32'b001);
    model_run(50);
    pulse_start();
    wait_req("t4_resume_req", 20);
    check("t4_resume_addr", 32'(Imem_addr), 32'h5);
    wait_drain("t4_resume_issue", 50);
    wait_halted("t4_resume_halt_pc", 50);

    // Stall held through ISSUE; spurious acks outside FETCH must be ignored.
    do_reset();
    fill_halt();
    mem[0] = 8'h5C;
    mem_lat = 0;
    force_stall = 1'b1;
    spur_en = 1'b1;
    model_run(50);
    repeat (2) @(posedge Clk);
    pulse_start();
    wait_req("t5_req", 20);
    seen_drop = 1'b0;
    for (int c = 0; c < 20 && !seen_drop; c++) begin
      @(negedge Clk);
      seen_drop = !Imem_req;
    end
    if (!seen_drop) timeout_fail("t5_ack", 20);
    for (int c = 0; c < 3; c++) begin
      check("t5_stalled_en", 32'(En), 32'h0);
      if (c < 2) @(negedge Clk);
    end
    force_stall = 1'b0;
    wait_drain("t5_issue", 50);
    wait_halted("t5_halt_pc", 50);
    spur_en = 1'b0;

    // Randomized programs with forward jumps, random stalls and latencies, then a resume.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      fill_halt();
      l = $urandom_range(4, 20);
      for (int a = 0; a < l; a++) begin
        if ($urandom_range(0, 4) == 0) mem[a] = {3'b111, 5'($urandom_range(a + 1, l))};
        else mem[a] = rand_normal();
      end
      mem_lat    = $urandom_range(0, 3);
      stall_rand = 1'b1;
      spur_en    = 1'b1;
      model_run(100);
      pulse_start();
      wait_drain("rand_issues", 1500);
      wait_halted("rand_halt_pc", 200);
      model_run(100);
      pulse_start();
      wait_halted("rand_resume_pc", 200);
    end
    stall_rand = 1'b0;
    spur_en    = 1'b0;

    // Walk the PC through 0xFF so it wraps to 0x00.
    do_reset();
    mem[0] = 8'hE1;
    for (int a = 1; a < 256; a++) mem[a] = rand_normal();
    mem_lat = 0;
    model_run(1);
    pulse_start();
    wait_drain("t6_first_jmp", 50);
    mem[0] = 8'h20;
    model_run(300);
    wait_drain("t6_wrap_issues", 3000);
    wait_halted("t6_halt_pc", 50);
    check("t6_pc_after_wrap", 32'(PC), 32'h1);

    // Reset in the middle of a long fetch drops the request at once.
    mem_lat = 20;
    pulse_start();
    wait_req("t6_slow_req", 20);
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("t6_async_reset", 32'({Imem_req, Busy, Halted, PC}), 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("t6_idle_after_reset", 32'({Imem_req, Busy, Halted, En}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
